// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bundle.
// Carries the per-stage register indices and control bits from the pipeline
// and the data-memory handshake into the controller. It also carries the
// stage enables, flushes and forward selects back out.
//   master : the hazard controller (drives enables/flushes/fwd/dmem_req)
//   slave  : the pipeline datapath + data memory side
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs, id_rt;
  logic             id_use_rs, id_use_rt;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_rd;
  logic             ex_reg_write, ex_mem_read, ex_branch_tkn;
  logic [REG_W-1:0] mem_rd;
  logic             mem_reg_write, mem_access;
  logic [REG_W-1:0] wb_rd;
  logic             wb_reg_write;
  logic             dmem_ack;
  logic             dmem_req;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, memwb_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_err;

  modport master (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd,
           ex_reg_write, ex_mem_read, ex_branch_tkn, mem_rd, mem_reg_write,
           mem_access, wb_rd, wb_reg_write, dmem_ack,
    output dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, mem_err
  );

  modport slave (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd,
           ex_reg_write, ex_mem_read, ex_branch_tkn, mem_rd, mem_reg_write,
           mem_access, wb_rd, wb_reg_write, dmem_ack,
    input  dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, mem_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers of a
// 5-stage pipeline. It stalls on RAW hazards and squashes wrong-path
// instructions on taken branches. It runs the data-memory req/ack handshake
// with a timeout, and drives the PC/stage enables and flushes.
// Optional feature macro: FORWARD_EN. When it is defined, only load-use
// stalls and the EX operand forward selects are driven. When it is
// undefined, the controller stalls until the producer reaches WB, and the
// forward selects are tied to 00.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pipeline_hazard_ctrl_if.master:
//            stage indices/controls and dmem_ack in;
//            dmem_req, stage enables/flushes, fwd_a/fwd_b and mem_err out
// Every output except mem_err is combinational from the state and inputs.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.master bus
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [REG_W-1:0] R0      = '0;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            mem_err_q;
  logic            hazard;
  logic [1:0]      fwd_a_c, fwd_b_c;

  // A used source that matches a writing, non-r0 destination.
  function automatic logic raw(input logic [REG_W-1:0] src, input logic use_src,
                               input logic [REG_W-1:0] dst, input logic wr);
    return use_src && wr && (dst != R0) && (src == dst);
  endfunction

`ifdef FORWARD_EN
  // The youngest producer wins, so EX/MEM is checked before MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] m_rd, input logic m_wr,
                                         input logic [REG_W-1:0] w_rd, input logic w_wr);
    if (m_wr && m_rd != R0 && m_rd == src) return 2'b10;
    if (w_wr && w_rd != R0 && w_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // A load result only exists after MEM, so a load-use pair cannot be forwarded.
  assign hazard  = raw(bus.id_rs, bus.id_use_rs, bus.ex_rd, bus.ex_mem_read)
                 | raw(bus.id_rt, bus.id_use_rt, bus.ex_rd, bus.ex_mem_read);
  assign fwd_a_c = fwd_sel(bus.ex_rs, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write);
  assign fwd_b_c = fwd_sel(bus.ex_rt, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write);
`else
  // There is no bypass path. The regfile writes in the first half-cycle, so
  // a producer in WB is already visible and only EX and MEM producers stall.
  assign hazard  = raw(bus.id_rs, bus.id_use_rs, bus.ex_rd,  bus.ex_reg_write)
                 | raw(bus.id_rt, bus.id_use_rt, bus.ex_rd,  bus.ex_reg_write)
                 | raw(bus.id_rs, bus.id_use_rs, bus.mem_rd, bus.mem_reg_write)
                 | raw(bus.id_rt, bus.id_use_rt, bus.mem_rd, bus.mem_reg_write);
  assign fwd_a_c = 2'b00;
  assign fwd_b_c = 2'b00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      to_cnt    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.mem_access && !bus.dmem_ack) begin
            state  <= MEM_WAIT;
            to_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ack) begin
            state  <= RUN;
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state     <= ERROR;
            mem_err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ERROR:   mem_err_q <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  // Enables are {pc, ifid, idex, exmem, memwb}; flushes are {ifid, idex, memwb}.
  logic       req;
  logic [4:0] en;
  logic [2:0] fl;
  logic [1:0] fa, fb;

  always_comb begin
    req = 1'b0;
    en  = '0;
    fl  = '0;
    fa  = 2'b00;
    fb  = 2'b00;
    if (rst) begin
      fl = 3'b111;
    end else begin
      fa = fwd_a_c;
      fb = fwd_b_c;
      case (state)
        RUN: begin
          req = bus.mem_access;
          if (bus.mem_access && !bus.dmem_ack) begin
            en = '0;                // first cycle of a wait: freeze everything
          end else if (bus.ex_branch_tkn) begin
            en = '1;                // squash overrides any stall
            fl = 3'b110;
          end else if (hazard) begin
            en = 5'b00111;          // hold PC and IF/ID, load a bubble into ID/EX
            fl = 3'b010;
          end else begin
            en = '1;
          end
        end
        MEM_WAIT: req = bus.mem_access;   // frozen, including the ack cycle
        default:  ;                       // ERROR: everything held, no request
      endcase
    end
  end

  assign bus.dmem_req    = req;
  assign bus.pc_en       = en[4];
  assign bus.ifid_en     = en[3];
  assign bus.idex_en     = en[2];
  assign bus.exmem_en    = en[1];
  assign bus.memwb_en    = en[0];
  assign bus.ifid_flush  = fl[2];
  assign bus.idex_flush  = fl[1];
  assign bus.memwb_flush = fl[0];
  assign bus.fwd_a       = fa;
  assign bus.fwd_b       = fb;
  assign bus.mem_err     = mem_err_q;
endmodule
